// File: rtl/lif_spike_monitor.sv
// lif_spike_monitor: per-window spike rate (rate_count/rate_sat/rate_valid) and inter-spike interval (isi/isi_valid) of spike_in over a win_sel-selected window, busy while counting
module lif_spike_monitor #(
  parameter int CNT_W = 8,
  parameter int ISI_W = 8,
  parameter int WIN_W = 14
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             spike_in,
  input  logic [1:0]       win_sel,
  output logic [CNT_W-1:0] rate_count,
  output logic             rate_valid,
  output logic             rate_sat,
  output logic [ISI_W-1:0] isi,
  output logic             isi_valid,
  output logic             busy
);
  typedef enum logic {IDLE, COUNT} state_t;
  state_t state_q, state_d;
  logic spike_q, rise, win_end, cnt_max, sat_inc;
  logic [1:0] win_len_q, win_len_d;
  logic [WIN_W-1:0] win_cnt_q, win_cnt_d, win_last;
  logic [CNT_W-1:0] spike_cnt_q, spike_cnt_d, rate_count_q, rate_count_d, cnt_inc;
  logic sat_q, sat_d, rate_sat_q, rate_sat_d, rate_valid_q, rate_valid_d;
  logic [ISI_W-1:0] isi_cnt_q, isi_cnt_d, isi_q, isi_d;
  logic seen_q, seen_d, isi_valid_q, isi_valid_d;
  always_comb begin
    rise = spike_in & ~spike_q;
    win_last = (WIN_W'(256) << {win_len_q, 1'b0}) - WIN_W'(1);
    win_end = win_cnt_q == win_last;
    cnt_max = &spike_cnt_q;
    cnt_inc = rise ? (cnt_max ? spike_cnt_q : spike_cnt_q + CNT_W'(1)) : spike_cnt_q;
    sat_inc = sat_q | (rise & cnt_max);
    state_d = state_q;
    win_len_d = win_len_q;
    win_cnt_d = win_cnt_q;
    spike_cnt_d = spike_cnt_q;
    sat_d = sat_q;
    rate_count_d = rate_count_q;
    rate_sat_d = rate_sat_q;
    rate_valid_d = 1'b0;
    isi_cnt_d = isi_cnt_q;
    isi_d = isi_q;
    seen_d = seen_q;
    isi_valid_d = 1'b0;
    if (state_q == IDLE) begin
      win_cnt_d = '0;
      spike_cnt_d = '0;
      sat_d = 1'b0;
      isi_cnt_d = '0;
      seen_d = 1'b0;
      if (ena) begin
        state_d = COUNT;
        win_len_d = win_sel;
      end
    end else if (!ena) begin
      state_d = IDLE;
    end else begin
      win_cnt_d = win_end ? '0 : win_cnt_q + WIN_W'(1);
      spike_cnt_d = win_end ? '0 : cnt_inc;
      sat_d = win_end ? 1'b0 : sat_inc;
      if (win_end) begin
        rate_count_d = cnt_inc;
        rate_sat_d = sat_inc;
        rate_valid_d = 1'b1;
        win_len_d = win_sel;
      end
      isi_cnt_d = rise ? ISI_W'(1) : (&isi_cnt_q ? isi_cnt_q : isi_cnt_q + ISI_W'(1));
      seen_d = seen_q | rise;
      if (rise && seen_q) begin
        isi_d = isi_cnt_q;
        isi_valid_d = 1'b1;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      spike_q <= 1'b0;
      win_len_q <= '0;
      win_cnt_q <= '0;
      spike_cnt_q <= '0;
      sat_q <= 1'b0;
      rate_count_q <= '0;
      rate_sat_q <= 1'b0;
      rate_valid_q <= 1'b0;
      isi_cnt_q <= '0;
      isi_q <= '0;
      seen_q <= 1'b0;
      isi_valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      spike_q <= spike_in;
      win_len_q <= win_len_d;
      win_cnt_q <= win_cnt_d;
      spike_cnt_q <= spike_cnt_d;
      sat_q <= sat_d;
      rate_count_q <= rate_count_d;
      rate_sat_q <= rate_sat_d;
      rate_valid_q <= rate_valid_d;
      isi_cnt_q <= isi_cnt_d;
      isi_q <= isi_d;
      seen_q <= seen_d;
      isi_valid_q <= isi_valid_d;
    end
  end
  assign rate_count = rate_count_q;
  assign rate_valid = rate_valid_q;
  assign rate_sat = rate_sat_q;
  assign isi = isi_q;
  assign isi_valid = isi_valid_q;
  assign busy = state_q == COUNT;
endmodule

// File: tb/tb_lif_spike_monitor.sv
// tb_lif_spike_monitor: randomized and directed stimulus against a timestamp-based reference model with valid-driven scoreboard
module tb_lif_spike_monitor;
  logic clk = 1'b0, rst_n = 1'b0, ena = 1'b0, spike_in = 1'b0;
  logic [1:0] win_sel = 2'd0;
  logic [7:0] rate_count, isi;
  logic rate_valid, rate_sat, isi_valid, busy;
  int n_chk = 0, n_fail = 0;
  int rq_cnt[$], rq_sat[$], iq[$];
  bit m_active = 0, m_prev = 0, m_seen = 0, rise, done = 0;
  int t = 0, m_pos, m_len, m_edges, m_last;
  int h_rate = 0, h_sat = 0, h_isi = 0;
  lif_spike_monitor dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .spike_in(spike_in), .win_sel(win_sel),
    .rate_count(rate_count), .rate_valid(rate_valid), .rate_sat(rate_sat),
    .isi(isi), .isi_valid(isi_valid), .busy(busy)
  );
  always #5 clk = ~clk;
  function automatic int sat255(int v);
    return v > 255 ? 255 : v;
  endfunction
  always @(posedge clk) begin
    t = t + 1;
    rise = spike_in && !m_prev;
    m_prev = rst_n && spike_in;
    if (!rst_n) begin
      m_active = 0;
      rq_cnt.delete();
      rq_sat.delete();
      iq.delete();
    end else if (!m_active) begin
      if (ena) begin
        m_active = 1;
        m_pos = 0;
        m_len = 256 << (2 * int'(win_sel));
        m_edges = 0;
        m_seen = 0;
      end
    end else if (!ena) begin
      m_active = 0;
    end else begin
      if (rise) begin
        m_edges++;
        if (m_seen) iq.push_back(sat255(t - m_last));
        m_seen = 1;
        m_last = t;
      end
      if (m_pos == m_len - 1) begin
        rq_cnt.push_back(sat255(m_edges));
        rq_sat.push_back(m_edges > 255 ? 1 : 0);
        m_edges = 0;
        m_pos = 0;
        m_len = 256 << (2 * int'(win_sel));
      end else m_pos++;
    end
  end
  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at t=%0d: got %0d expected %0d", nm, t, act, exp);
    end
  endtask
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        h_rate = 0;
        h_sat = 0;
        h_isi = 0;
        chk("reset rate_count", int'(rate_count), 0);
        chk("reset rate_valid", int'(rate_valid), 0);
        chk("reset rate_sat", int'(rate_sat), 0);
        chk("reset isi", int'(isi), 0);
        chk("reset isi_valid", int'(isi_valid), 0);
        chk("reset busy", int'(busy), 0);
      end else begin
        chk("busy", int'(busy), int'(m_active));
        if (rate_valid) begin
          if (rq_cnt.size() == 0) chk("unexpected rate_valid", 1, 0);
          else begin
            h_rate = rq_cnt.pop_front();
            h_sat = rq_sat.pop_front();
            chk("rate_count", int'(rate_count), h_rate);
            chk("rate_sat", int'(rate_sat), h_sat);
          end
        end else begin
          chk("rate_count hold", int'(rate_count), h_rate);
          chk("rate_sat hold", int'(rate_sat), h_sat);
        end
        if (isi_valid) begin
          if (iq.size() == 0) chk("unexpected isi_valid", 1, 0);
          else begin
            h_isi = iq.pop_front();
            chk("isi", int'(isi), h_isi);
          end
        end else chk("isi hold", int'(isi), h_isi);
      end
      if (done) begin
        chk("rate pulses missing", rq_cnt.size(), 0);
        chk("isi pulses missing", iq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
      end
    end
  end
  task automatic drv(input logic r, input logic e, input logic s, input logic [1:0] w);
    @(negedge clk);
    rst_n = r;
    ena = e;
    spike_in = s;
    win_sel = w;
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drv(1, 0, 0, 0);
  endtask
  initial begin
    drv(0, 1, 1, 0);
    drv(0, 1, 0, 0);
    idle(2);
    drv(1, 1, 0, 0);
    for (int i = 0; i < 3 * 256 + 4; i++) drv(1, 1, i % 16 == 0, 0);
    idle(2);
    drv(1, 1, 0, 0);
    for (int i = 0; i < 5; i++) drv(1, 1, 0, 0);
    for (int i = 0; i < 5; i++) drv(1, 1, 1, 0);
    for (int i = 0; i < 20; i++) drv(1, 1, 0, 0);
    for (int i = 0; i < 5; i++) drv(1, 1, 1, 0);
    for (int i = 0; i < 10; i++) drv(1, 1, 0, 0);
    idle(2);
    drv(1, 1, 0, 1);
    for (int i = 0; i < 1024; i++) drv(1, 1, i % 2 == 0, 1);
    for (int i = 0; i < 1030; i++) drv(1, 1, 0, 1);
    idle(2);
    drv(1, 1, 0, 1);
    drv(1, 1, 1, 1);
    for (int i = 0; i < 999; i++) drv(1, 1, 0, 1);
    drv(1, 1, 1, 1);
    drv(1, 1, 0, 1);
    idle(2);
    drv(1, 1, 0, 0);
    for (int i = 0; i < 100; i++) drv(1, 1, i % 7 == 3, 0);
    idle(5);
    drv(1, 1, 0, 0);
    for (int i = 0; i < 2 * 256 + 4; i++) drv(1, 1, i == 255, 0);
    idle(2);
    for (int i = 0; i < 4000; i++) begin
      logic r, e, s;
      logic [1:0] w;
      r = $urandom_range(0, 999) != 0;
      e = $urandom_range(0, 299) != 0;
      s = $urandom_range(0, 3) == 0;
      w = $urandom_range(0, 7) == 0 ? 2'd1 : 2'd0;
      drv(r, e, s, w);
    end
    idle(3);
    done = 1;
  end
endmodule
